// File: rtl/cic_interp_pdm.sv
`default_nettype none
// ============================================================================
// Module  : cic_interp_pdm
// Purpose : PCM-to-PDM transmitter. N-stage CIC interpolator by R followed by
//           a first-order sigma-delta modulator with a generated bit clock.
// Revision: 1.0 - initial release
// ============================================================================
module cic_interp_pdm #(
    parameter int IN_W    = 24,
    parameter int R       = 64,
    parameter int N       = 3,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            pdm_clk,
    output logic            pdm_out,
    output logic            underrun
);
    localparam int c_log2r  = $clog2(R);
    localparam int c_w      = IN_W + N * c_log2r;
    localparam int c_shift  = (N - 1) * c_log2r;
    localparam int c_div_w  = $clog2(CLK_DIV);
    localparam int c_acc_w  = IN_W + 2;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
    localparam logic signed [c_acc_w-1:0] c_fs     = {2'b00, 1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [c_acc_w-1:0] c_fs_neg = -c_fs;

    // Bit-clock divider and sample phase
    logic [c_div_w-1:0] r_div_cnt;
    logic [c_div_w-1:0] w_div_nxt;
    logic [c_log2r-1:0] r_phase;
    logic               w_tick;
    logic               w_slot;
    logic               r_pdm_clk;

    assign w_tick    = (r_div_cnt == c_div_last);
    assign w_slot    = w_tick && (r_phase == '0);
    assign w_div_nxt = w_tick ? '0 : r_div_cnt + c_div_w'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_phase   <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_pdm_clk <= (w_div_nxt >= c_div_half);
            if (w_tick)
                r_phase <= r_phase + c_log2r'(1);
        end
    end

    // Holding register. r_hold keeps its value after consumption, so an
    // empty slot naturally re-uses the last consumed sample.
    logic                   r_full;
    logic signed [IN_W-1:0] r_hold;
    logic                   r_underrun;

    assign s_ready = ~(r_full | rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= 1'b0;
            r_hold     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_slot && !r_full;
            if (w_slot)
                r_full <= 1'b0;
            if (s_valid && s_ready) begin
                r_full <= 1'b1;
                r_hold <= s_data;
            end
        end
    end

    // Comb chain at the sample rate, zero-stuffing, integrators at the bit rate
    logic signed [c_w-1:0] r_cd  [N];
    logic signed [c_w-1:0] r_int [N];
    logic signed [c_w-1:0] w_cin [N];
    logic signed [c_w-1:0] w_d;
    logic signed [c_w-1:0] w_u;

    always_comb begin
        w_d = c_w'(r_hold);
        for (int i = 0; i < N; i++) begin
            w_cin[i] = w_d;
            w_d      = w_d - r_cd[i];
        end
    end

    assign w_u = w_slot ? w_d : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cd[i]  <= '0;
                r_int[i] <= '0;
            end
        end else begin
            if (w_slot)
                for (int i = 0; i < N; i++)
                    r_cd[i] <= w_cin[i];
            if (w_tick) begin
                r_int[0] <= r_int[0] + w_u;
                for (int i = 1; i < N; i++)
                    r_int[i] <= r_int[i] + r_int[i-1];
            end
        end
    end

    // Remove the R^(N-1) CIC gain, then clamp to the PCM range
    logic signed [c_w-1:0]  w_shift;
    logic                   w_in_range;
    logic signed [IN_W-1:0] w_x;

    assign w_shift    = r_int[N-1] >>> c_shift;
    assign w_in_range = (w_shift[c_w-1:IN_W-1] == '0) || (w_shift[c_w-1:IN_W-1] == '1);

    always_comb begin
        w_x = w_shift[IN_W-1:0];
        if (!w_in_range)
            w_x = w_shift[c_w-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    end

    // First-order sigma-delta modulator
    logic signed [c_acc_w-1:0] r_acc;
    logic signed [c_acc_w-1:0] w_acc_nxt;
    logic                      w_b;
    logic                      r_pdm;

    assign w_b       = ~r_acc[c_acc_w-1];
    assign w_acc_nxt = r_acc + c_acc_w'(w_x) - (w_b ? c_fs : c_fs_neg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else if (w_tick) begin
            r_acc <= w_acc_nxt;
            r_pdm <= w_b;
        end
    end

    assign pdm_clk  = r_pdm_clk;
    assign pdm_out  = r_pdm;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_interp_pdm.sv
`default_nettype none
// ============================================================================
// Module  : tb_cic_interp_pdm
// Purpose : Self-checking bench for cic_interp_pdm against a convolution model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cic_interp_pdm;
    localparam int IN_W    = 24;
    localparam int R       = 64;
    localparam int N       = 3;
    localparam int CLK_DIV = 4;
    localparam int c_shift = (N - 1) * $clog2(R);
    localparam int c_glen  = N * (R - 1) + 1;
    localparam longint c_fs = longint'(1) << (IN_W - 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IN_W-1:0] s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            pdm_clk;
    logic            pdm_out;
    logic            underrun;

    always #5 clk = ~clk;

    cic_interp_pdm #(.IN_W(IN_W), .R(R), .N(N), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .pdm_clk  (pdm_clk),
        .pdm_out  (pdm_out),
        .underrun (underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference: the whole interpolator is the zero-stuffed sample stream
    // convolved with N cascaded length-R boxcars, delayed N-1 ticks.
    longint g [c_glen];

    task automatic build_kernel();
        longint tmp [c_glen];
        int len = 1;
        for (int i = 0; i < c_glen; i++) g[i] = 0;
        g[0] = 1;
        repeat (N) begin
            for (int i = 0; i < c_glen; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++)
                    tmp[i+j] += g[i];
            len += R - 1;
            g = tmp;
        end
    endtask

    typedef struct {int t; longint v;} slot_t;
    slot_t  m_slots [$];
    int     m_div = 0, m_phase = 0, m_tick = 0, m_slot_cnt = 0;
    bit     m_full = 0, m_pdm = 0, m_und = 0, m_pclk = 0;
    longint m_hold = 0, m_last = 0, m_acc = 0, m_in = 0;

    function automatic longint cic_out(int t);
        longint s = 0;
        int k;
        foreach (m_slots[i]) begin
            k = t - m_slots[i].t - (N - 1);
            if (k >= 0 && k < c_glen) s += m_slots[i].v * g[k];
        end
        return s;
    endfunction

    function automatic longint norm(longint v);
        longint y = v >>> c_shift;
        if (y > c_fs - 1) y = c_fs - 1;
        if (y < -c_fs) y = -c_fs;
        return y;
    endfunction

    always @(posedge clk) begin
        bit     tick, slot, xfer;
        longint cin, x_pre;
        if (rst) begin
            m_div = 0; m_phase = 0; m_tick = 0;
            m_full = 0; m_pdm = 0; m_und = 0; m_pclk = 0;
            m_hold = 0; m_last = 0; m_acc = 0; m_in = 0;
            m_slots.delete();
        end else begin
            tick  = (m_div == CLK_DIV - 1);
            slot  = tick && (m_phase == 0);
            xfer  = s_valid && !m_full;
            m_und = slot && !m_full;
            if (tick) begin
                x_pre = norm(m_in);
                m_pdm = (m_acc >= 0);
                m_acc = m_acc + x_pre - (m_pdm ? c_fs : -c_fs);
                if (slot) begin
                    cin    = m_full ? m_hold : m_last;
                    m_last = cin;
                    m_slots.push_back('{m_tick, cin});
                    m_slot_cnt++;
                end
                m_in = cic_out(m_tick);
                m_tick++;
                while (m_slots.size() > 0 && m_tick - m_slots[0].t > c_glen + N)
                    void'(m_slots.pop_front());
            end
            if (slot) m_full = 0;
            if (xfer) begin
                m_full = 1;
                m_hold = longint'($signed(s_data));
            end
            m_div  = (m_div + 1) % CLK_DIV;
            if (tick) m_phase = (m_phase + 1) % R;
            m_pclk = (m_div >= CLK_DIV / 2);
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        check_val("s_ready",  longint'(s_ready),  longint'(rst ? 1'b0 : !m_full));
        check_val("pdm_clk",  longint'(pdm_clk),  longint'(m_pclk));
        check_val("pdm_out",  longint'(pdm_out),  longint'(m_pdm));
        check_val("underrun", longint'(underrun), longint'(m_und));
        check_val("x",        longint'($signed(dut.w_x)), norm(m_in));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_ones(output int ones);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            ones += int'(pdm_out);
            step(CLK_DIV);
        end
    endtask

    task automatic count_pulses(input int cycles, output int n_und, output int n_rdy);
        n_und = 0;
        n_rdy = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            n_und += int'(underrun);
            n_rdy += int'(s_ready);
        end
    endtask

    initial begin
        int ones, n_und, n_rdy, n, s0;
        build_kernel();

        // Reset and idle
        step(3);
        rst = 1'b0;
        step(1);
        count_pulses(4 * R * CLK_DIV, n_und, n_rdy);
        check_val("idle_underruns", n_und, 4);

        // DC zero, always valid
        s_data  = '0;
        s_valid = 1'b1;
        step(300);
        count_pulses(4 * R * CLK_DIV, n_und, n_rdy);
        check_val("dc0_ready_pulses", n_rdy, 4);
        check_val("dc0_underruns", n_und, 0);

        // DC half scale
        s_data = IN_W'(1 << 22);
        step((N + 2) * R * CLK_DIV);
        check_val("dcpos_x", longint'($signed(dut.w_x)), longint'(1) << 22);
        count_ones(ones);
        check_val("dcpos_density", longint'(ones >= 47 && ones <= 49), 1);

        // Full-scale step
        s_data = 24'h800000;
        step((N + 3) * R * CLK_DIV);
        check_val("fs_neg_x", longint'($signed(dut.w_x)), -c_fs);
        s_data = 24'h7fffff;
        step((N + 3) * R * CLK_DIV);
        check_val("fs_pos_x", longint'($signed(dut.w_x)), c_fs - 1);
        count_ones(ones);
        check_val("fs_density", longint'(ones >= 63), 1);

        // Underrun hold
        s_data = IN_W'(1 << 21);
        step((N + 2) * R * CLK_DIV);
        n = 0;
        while (!m_full && n < 2 * R * CLK_DIV) begin step(1); n++; end
        check_val("wait_full", longint'(m_full), 1);
        s_valid = 1'b0;
        s0 = m_slot_cnt;
        n_und = 0;
        n = 0;
        while (m_slot_cnt < s0 + 4 && n < 5 * R * CLK_DIV) begin
            step(1);
            n++;
            n_und += int'(underrun);
        end
        check_val("hold_slots_seen", m_slot_cnt, s0 + 4);
        check_val("hold_underruns", n_und, 3);
        s_valid = 1'b1;
        step(8);
        check_val("hold_x", longint'($signed(dut.w_x)), longint'(1) << 21);
        count_ones(ones);
        check_val("hold_density", longint'(ones >= 39 && ones <= 41), 1);

        // Random data with random valid gaps
        for (int i = 0; i < 4000; i++) begin
            s_data  = IN_W'($urandom);
            s_valid = ($urandom_range(0, 3) != 0);
            step(1);
        end

        // Mid-stream reset while a sample is held and the modulator is busy
        s_valid = 1'b1;
        n = 0;
        while (!(m_full && m_acc != 0) && n < 4 * R * CLK_DIV) begin
            s_data = IN_W'($urandom);
            step(1);
            n++;
        end
        check_val("wait_busy", longint'(m_full && m_acc != 0), 1);
        s_valid = 1'b0;
        rst     = 1'b1;
        step(1);
        rst = 1'b0;
        check_val("rst_pdm_out",  longint'(pdm_out), 0);
        check_val("rst_pdm_clk",  longint'(pdm_clk), 0);
        check_val("rst_underrun", longint'(underrun), 0);
        check_val("rst_x",        longint'($signed(dut.w_x)), 0);
        step(CLK_DIV);
        check_val("rst_first_bit", longint'(pdm_out), 1);
        step(CLK_DIV);
        check_val("rst_second_bit", longint'(pdm_out), 0);
        step(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
